// File: rtl/lifo_drain_if.sv
// Output stream of the LIFO drain block: one word per valid/ready transfer,
// with last_o set on the word that emptied the LIFO.
interface lifo_drain_if #(
    parameter int DWIDTH = 8
) ();
    logic [DWIDTH-1:0] data_o;
    logic              valid_o;
    logic              last_o;
    logic              ready_i;

    // A word transfers on a rising edge where valid_o & ready_i.
    // While valid_o=1 and ready_i=0, data_o and last_o stay frozen and valid_o
    // stays high. valid_o never depends on ready_i.
    modport master (output data_o, output valid_o, output last_o, input ready_i);
    modport slave  (input data_o, input valid_o, input last_o, output ready_i);
endinterface

// File: rtl/lifo_drain.sv
// Drains the LIFO to empty, newest first, once it holds a full batch or on flush.
// A 2-entry output buffer covers the LIFO's 1-cycle read latency.
module lifo_drain #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3,
    parameter int THRESH = 2**AWIDTH
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              flush_i,
    input  logic              empty_i,
    input  logic [AWIDTH:0]   usedw_i,
    input  logic [DWIDTH-1:0] q_i,
    output logic              rdreq_o,
    output logic              busy_o,
    output logic [0:0]        state_dbg_o,
    lifo_drain_if.master      strm
);
    localparam logic [0:0]      IDLE     = 1'b0;
    localparam logic [0:0]      DRAIN    = 1'b1;
    localparam logic [AWIDTH:0] THRESH_W = THRESH[AWIDTH:0];
    localparam logic [AWIDTH:0] ONE_W    = {{AWIDTH{1'b0}}, 1'b1};

    logic [0:0]        state;
    logic              last_issued;
    logic              inflight;
    logic              inflight_last;
    logic [DWIDTH-1:0] sk_data;
    logic              sk_last;
    logic              sk_valid;
    logic [1:0]        occ;
    logic [2:0]        credit;
    logic              pop;
    logic              start;
    logic              rd_is_last;

    // Head entry is the visible output register; sk_* is the second slot.
    assign occ        = {sk_valid, strm.valid_o & ~sk_valid};
    assign pop        = strm.valid_o & strm.ready_i;
    assign credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign rd_is_last = (usedw_i == ONE_W);
    assign start      = (usedw_i >= THRESH_W) | (flush_i & ~empty_i);

    always_comb begin
        rdreq_o = 1'b0;
        if (state == DRAIN && !empty_i && !last_issued && credit < 3'd2)
            rdreq_o = 1'b1;
    end

    assign state_dbg_o = state;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            last_issued   <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rdreq_o;
            inflight_last <= rdreq_o & rd_is_last;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= DRAIN;
                        busy_o <= 1'b1;
                    end
                end
                default: begin
                    if (pop && strm.last_o) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        last_issued <= 1'b0;
                    end else if (rdreq_o && rd_is_last) begin
                        last_issued <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Push comes from the read issued last cycle; the credit rule keeps occ <= 2.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            strm.data_o  <= '0;
            strm.last_o  <= 1'b0;
            strm.valid_o <= 1'b0;
            sk_data      <= '0;
            sk_last      <= 1'b0;
            sk_valid     <= 1'b0;
        end else if (pop) begin
            if (sk_valid) begin
                strm.data_o <= sk_data;
                strm.last_o <= sk_last;
                sk_valid    <= inflight;
                if (inflight) begin
                    sk_data <= q_i;
                    sk_last <= inflight_last;
                end
            end else if (inflight) begin
                strm.data_o <= q_i;
                strm.last_o <= inflight_last;
            end else begin
                strm.valid_o <= 1'b0;
                strm.last_o  <= 1'b0;
            end
        end else if (inflight) begin
            if (strm.valid_o) begin
                sk_data  <= q_i;
                sk_last  <= inflight_last;
                sk_valid <= 1'b1;
            end else begin
                strm.data_o  <= q_i;
                strm.last_o  <= inflight_last;
                strm.valid_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lifo_drain.sv
// Bench for lifo_drain: behavioural LIFO in front, scoreboard on the stream side.
module tb_lifo_drain;
  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       flush = 1'b0;
  logic       empty;
  logic [3:0] usedw;
  logic [7:0] q = 8'h00;
  logic       rdreq;
  logic       busy;
  logic [0:0] state_dbg;

  lifo_drain_if #(.DWIDTH(8)) s ();

  lifo_drain #(.DWIDTH(8), .AWIDTH(3), .THRESH(8)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .flush_i(flush), .empty_i(empty),
    .usedw_i(usedw), .q_i(q), .rdreq_o(rdreq), .busy_o(busy),
    .state_dbg_o(state_dbg), .strm(s.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- behavioural LIFO, 1-cycle read latency ----------------
  logic [7:0] mem [8];
  int         cnt = 0;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;

  assign empty = (cnt == 0);
  assign usedw = 4'(cnt);

  always @(posedge clk) begin
    if (wr) begin
      mem[cnt[2:0]] <= wdata;
      cnt <= cnt + 1;
    end else if (rdreq) begin
      q <= mem[3'(cnt - 1)];
      cnt <= cnt - 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  int         cyc = 0;
  int         first_rd_cyc = -1;
  int         first_vld_cyc = -1;
  int         last_xfer_cyc = -1;
  int         n_xfer = 0;
  int         outstanding = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;
  logic       last_prev = 1'b0;
  logic [8:0] e;

  // Monitor: all DUT outputs sampled at the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!arst_n) begin
      outstanding = 0;
      stall_prev = 1'b0;
      last_prev = 1'b0;
    end else begin
      if (last_prev) begin
        check("busy_after_last", {31'd0, busy}, 32'd0);
        check("idle_after_last", {31'd0, state_dbg}, 32'd0);
      end
      if (stall_prev) begin
        check("stall_valid_held", {31'd0, s.valid_o}, 32'd1);
        check("stall_data_held", {24'd0, s.data_o}, {24'd0, prev_data});
        check("stall_last_held", {31'd0, s.last_o}, {31'd0, prev_last});
      end
      if (rdreq && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (s.valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
      last_prev = 1'b0;
      if (s.valid_o && s.ready_i) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", {23'd0, s.last_o, s.data_o}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", {24'd0, s.data_o}, {24'd0, e[7:0]});
          check("stream_last", {31'd0, s.last_o}, {31'd0, e[8]});
        end
        if (s.last_o) begin
          last_prev = 1'b1;
          last_xfer_cyc = cyc;
        end
      end
      outstanding = outstanding + (rdreq ? 1 : 0) - ((s.valid_o && s.ready_i) ? 1 : 0);
      if (outstanding > 2) check("outstanding_le_2", outstanding, 2);
      stall_prev = s.valid_o & ~s.ready_i;
      prev_data = s.data_o;
      prev_last = s.last_o;
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic push_word(input logic [7:0] v);
    wr = 1'b1;
    wdata = v;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(name, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdreq"}, {31'd0, rdreq}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_valid"}, {31'd0, s.valid_o}, 32'd0);
    check({tag, "_last"}, {31'd0, s.last_o}, 32'd0);
    check({tag, "_data"}, {24'd0, s.data_o}, 32'd0);
    check({tag, "_state"}, {31'd0, state_dbg}, 32'd0);
  endtask

  task automatic fill_batch(input logic [7:0] base);
    for (int v = 8; v >= 1; v--) exp_q.push_back({(v == 1), base + 8'(v)});
    for (int v = 1; v <= 8; v++) push_word(base + 8'(v));
  endtask

  // ---------------- directed sequence ----------------
  logic saw_busy, saw_rd, held_valid;

  initial begin
    s.ready_i = 1'b1;
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    arst_n = 1'b1;
    idle_cycles(2);

    // 1: full batch, free-running consumer
    first_rd_cyc = -1; first_vld_cyc = -1; last_xfer_cyc = -1;
    fill_batch(8'h00);
    wait_idle("t1_drain_done", 40);
    check("t1_latency", first_vld_cyc - first_rd_cyc, 2);
    check("t1_back_to_back", last_xfer_cyc - first_vld_cyc, 7);

    // 2: same fill, consumer ready toggling
    s.ready_i = 1'b0;
    fill_batch(8'h00);
    for (int i = 0; i < 30; i++) begin
      s.ready_i = ~s.ready_i;
      @(posedge clk); #1;
    end
    s.ready_i = 1'b1;
    wait_idle("t2_drain_done", 40);

    // 3: partial fill with flush
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h0B});
    exp_q.push_back({1'b1, 8'h0A});
    push_word(8'h0A); push_word(8'h0B); push_word(8'h0C);
    idle_cycles(2);
    check("t3_no_start_below_thresh", {31'd0, busy}, 32'd0);
    pulse_flush();
    wait_idle("t3_drain_done", 30);
    check("t3_state_idle", {31'd0, state_dbg}, 32'd0);

    // 4: flush with an empty LIFO is ignored
    pulse_flush();
    saw_busy = 1'b0; saw_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_busy |= busy;
      saw_rd |= rdreq;
    end
    @(posedge clk); #1;
    check("t4_busy_stays_0", {31'd0, saw_busy}, 32'd0);
    check("t4_rdreq_stays_0", {31'd0, saw_rd}, 32'd0);

    // 5: single word, consumer stalls for 5 cycles
    exp_q.push_back({1'b1, 8'h55});
    push_word(8'h55);
    s.ready_i = 1'b0;
    pulse_flush();
    idle_cycles(3);
    held_valid = 1'b1; saw_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      held_valid &= s.valid_o;
      saw_rd |= rdreq;
    end
    @(posedge clk); #1;
    check("t5_valid_held", {31'd0, held_valid}, 32'd1);
    check("t5_no_reissue", {31'd0, saw_rd}, 32'd0);
    s.ready_i = 1'b1;
    wait_idle("t5_drain_done", 20);

    // 6: reset after the third transfer of a full batch
    n_xfer = 0;
    fill_batch(8'h00);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (n_xfer == 3) break;
    end
    check("t6_three_transfers", n_xfer, 3);
    #1;
    arst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    // five reads issued by the third transfer: words 8..4 left the LIFO
    check("t6_lifo_remaining", cnt, 3);
    @(posedge clk); #1;
    arst_n = 1'b1;
    for (int v = 8'h25; v >= 8'h21; v--) exp_q.push_back({1'b0, 8'(v)});
    exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b1, 8'h01});
    for (int v = 8'h21; v <= 8'h25; v++) push_word(8'(v));
    wait_idle("t6_drain_done", 40);
    check("t6_lifo_empty", cnt, 0);

    idle_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
